// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with 4-word blocks and a single-block refill FSM.
// Optional hit/miss counters are enabled with ICACHE_STATS_EN.
module instr_cache #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [31:0]                    PC,
  output logic [31:0]                    INSTRUCTION,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  input  logic [127:0]                   MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                    HIT_COUNT,
  output logic [15:0]                    MISS_COUNT
`endif
);

  localparam int unsigned ADDR_W = TAG_BITS + INDEX_BITS;
  localparam int unsigned NBLK   = 1 << INDEX_BITS;
  localparam int unsigned TOP    = ADDR_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_e;

  state_e                state_q, state_d;
  logic                  first_q, first_d;
  logic [ADDR_W-1:0]     refill_addr_q, refill_addr_d;
  logic [127:0]          refill_data_q, refill_data_d;
  logic [NBLK-1:0]       valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_mem [NBLK];
  logic [127:0]          data_mem [NBLK];

  logic [1:0]            pc_off;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [127:0]          line_c;
  logic                  hit_c;
  logic                  busy_c;
  logic                  mem_read_c;
  logic                  unused_pc_bits;

  assign pc_off         = PC[3:2];
  assign pc_idx         = PC[INDEX_BITS+3:4];
  assign pc_tag         = PC[TOP-1:INDEX_BITS+4];
  assign unused_pc_bits = ^{PC[31:TOP], PC[1:0]};
  assign fill_idx       = refill_addr_q[INDEX_BITS-1:0];
  assign fill_tag       = refill_addr_q[ADDR_W-1:INDEX_BITS];

  assign hit_c  = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign line_c = data_mem[pc_idx];

  // Next-state and refill control
  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    refill_addr_d = refill_addr_q;
    refill_data_d = refill_data_q;
    valid_d       = valid_q;
    busy_c        = 1'b1;
    mem_read_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_c = !hit_c;
        if (!hit_c) begin
          refill_addr_d = {pc_tag, pc_idx};
          first_d       = 1'b1;
          state_d       = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        // The first cycle gives memory time to raise its busy flag.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!MEM_BUSYWAIT) begin
          refill_data_d = MEM_READDATA;
          state_d       = S_UPDATE;
        end
      end
      S_UPDATE: begin
        valid_d[fill_idx] = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_IDLE;
      first_q       <= 1'b0;
      refill_addr_q <= '0;
      refill_data_q <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      refill_addr_q <= refill_addr_d;
      refill_data_q <= refill_data_d;
      valid_q       <= valid_d;
    end
  end

  // Tag and data arrays are qualified by valid_q, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_UPDATE) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= refill_data_q;
    end
  end

  assign BUSYWAIT    = RESET & busy_c;
  assign MEM_READ    = RESET & mem_read_c;
  assign MEM_ADDRESS = MEM_READ ? refill_addr_q : '0;
  assign INSTRUCTION = RESET ? line_c[{pc_off, 5'd0} +: 32] : 32'h0;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Saturating event counters
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == S_IDLE) && hit_c && (hit_count_q != 16'hFFFF))
      hit_count_d = hit_count_q + 16'd1;
    if ((state_q == S_IDLE) && !hit_c && (miss_count_q != 16'hFFFF))
      miss_count_d = miss_count_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: flat-memory reference model, slow memory, random and directed fetches.
module tb_instr_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  PC = 32'h0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  instr_cache dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Backing store: flat word array; the slow memory is busy for 4 cycles of MEM_READ
  logic [31:0] mem_word [256];
  int          mem_cnt = 0;
  always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < 4);
  assign MEM_READDATA = {mem_word[{MEM_ADDRESS, 2'd3}], mem_word[{MEM_ADDRESS, 2'd2}],
                         mem_word[{MEM_ADDRESS, 2'd1}], mem_word[{MEM_ADDRESS, 2'd0}]};

  // Reference cache model: which block address each index currently holds
  bit          m_valid [8];
  logic [2:0]  m_tag [8];
  int          n_miss = 0;

  logic [31:0] exp_instr_q [$];
  int          exp_stall_q [$];
  logic [31:0] exp_blk_q [$];
  bit          req_active = 1'b0;
  int          stall_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  localparam int MISS_STALL = 7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] pc, input bit sync);
    logic [2:0] idx;
    logic [2:0] tg;
    bit         hit;
    if (sync) begin
      @(posedge CLK);
      #1;
    end
    PC  = pc;
    idx = pc[6:4];
    tg  = pc[9:7];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_instr_q.push_back(mem_word[pc[9:2]]);
    exp_stall_q.push_back(hit ? 0 : MISS_STALL);
    exp_blk_q.push_back({26'd0, pc[9:4]});
    if (!hit) n_miss++;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    req_active   = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      #1;
      if (!req_active) break;
    end
    if (req_active) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: pc %h still stalled after 60 cycles", pc);
      exp_instr_q.delete();
      exp_stall_q.delete();
      exp_blk_q.delete();
      stall_cnt  = 0;
      req_active = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    n_miss = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    chk("rst_instruction", INSTRUCTION, 32'd0);
  endtask

  // Monitor: counts stall cycles and checks each response when BUSYWAIT drops
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        if (!MEM_READ) chk("mem_address_idle", {26'd0, MEM_ADDRESS}, 32'd0);
        if (req_active && exp_instr_q.size() > 0) begin
          if (BUSYWAIT) begin
            stall_cnt++;
            if (MEM_READ) chk("mem_address", {26'd0, MEM_ADDRESS}, exp_blk_q[0]);
          end else begin
            chk("instruction", INSTRUCTION, exp_instr_q.pop_front());
            chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall_q.pop_front()));
            chk("mem_read_on_hit", {31'd0, MEM_READ}, 32'd0);
            void'(exp_blk_q.pop_front());
            stall_cnt  = 0;
            req_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] pc;
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      mem_word[i] = r;
    end
    mem_word[0] = 32'h00000001;
    mem_word[1] = 32'h00000004;
    mem_word[2] = 32'h00000008;
    mem_word[3] = 32'h0000000C;
    clear_model();

    // Reset state
    #12;
    chk_reset_outputs();
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // 1: cold miss at PC=0, then 2: three consecutive hits
    send(32'h0, 1'b0);
    send(32'h4, 1'b1);
    send(32'h8, 1'b1);
    send(32'hC, 1'b1);
`ifdef ICACHE_STATS_EN
    chk("miss_count_s12", {16'd0, MISS_COUNT}, 32'd1);
    chk("hit_count_min", {31'd0, HIT_COUNT >= 16'd4}, 32'd1);
`endif

    // 3: conflict miss evicts index 0; 4: other index leaves index 0 intact
    send(32'h80, 1'b1);
    send(32'h0, 1'b1);
    send(32'h10, 1'b1);
    send(32'h4, 1'b1);
    send(32'h1C, 1'b1);

    // Randomised fetches with a small tag range to mix hits and conflicts
    for (int n = 0; n < 300; n++) begin
      r  = $urandom();
      pc = {r[31:10], 3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), r[1:0]};
      send(pc, 1'b1);
    end

    // 5: reset during MEM_READ discards the fill
    @(posedge CLK);
    #1;
    PC = 32'h40;
    repeat (3) @(negedge CLK);
    chk("pre_rst_mem_read", {31'd0, MEM_READ}, 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outputs();
    @(posedge CLK);
    #1;
    clear_model();
    RESET = 1'b1;
    send(32'h40, 1'b0);
    send(32'h0, 1'b1);
    send(32'h44, 1'b1);

`ifdef ICACHE_STATS_EN
    chk("miss_count_model", {16'd0, MISS_COUNT}, 32'(n_miss));
    @(posedge CLK);
    #1;
    PC = 32'h0;
    repeat (70000) @(posedge CLK);
    #1;
    chk("hit_count_sat", {16'd0, HIT_COUNT}, 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
